// File: rtl/boot_pkg.sv
// Shared types for the boot loader: FSM states and error codes.
// Imported by boot_load_ctrl and word_packer.
package boot_pkg;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_COUNT   = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

endpackage

// File: rtl/boot_load_ctrl_word_packer.sv
// Packs LSB-first bytes into 32-bit words; word_ready_o marks the 4th byte.
// Ports: clk, reset, clear_i, en_i, byte_i -> word_o, word_ready_o.
module word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [31:0] lanes_q, lanes_d;
  logic [1:0]  idx_q, idx_d;

  // Bytes shift in from the top, so after three bytes the low
  // lanes sit in [31:8] and the 4th byte completes the word.
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clear_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (en_i) begin
      lanes_d = {byte_i, lanes_q[31:8]};
      idx_d   = idx_q + 2'd1;
    end
  end

  assign word_o       = {byte_i, lanes_q[31:8]};
  assign word_ready_o = en_i && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: receives a framed image over rx bytes, writes imem,
// releases the core on a good checksum, reloads on load_req.
// Ports: clk, reset, rx_valid, rx_data, load_req -> core_reset,
// imem_we, imem_addr, imem_wd, busy, done, err, err_code.
// Optional: define BOOT_TIMEOUT_EN for an inter-byte idle timeout.
module boot_load_ctrl
  import boot_pkg::*;
#(
  parameter int          MAX_WORDS      = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        load_req,
  output logic        core_reset,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        core_reset_q, core_reset_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  err_e        code_q, code_d;

  logic        pk_en, pk_clr;
  logic [31:0] pk_word;
  logic        pk_ready;
  logic [15:0] n_word;

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
`endif

  word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clr),
    .en_i         (pk_en),
    .byte_i       (rx_data),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  assign n_word = {rx_data, cnt_lo_q};

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;
    code_d     = code_q;
    pk_en      = 1'b0;
    pk_clr     = 1'b0;

    unique case (state_q)
      CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_d = rx_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          count_d = n_word;
          if (n_word == 16'd0 ||
              32'(n_word) > 32'(MAX_WORDS)) begin
            state_d = ERROR;
            code_d  = ERR_COUNT;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          pk_en  = 1'b1;
          csum_d = csum_q ^ rx_data;
          if (pk_ready) begin
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + (32'(word_idx_q) << 2);
            wd_d       = pk_word;
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1)
              state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = RUN;
          end else begin
            state_d = ERROR;
            code_d  = ERR_CSUM;
          end
        end
      end
      RUN: begin
        // load_req takes priority; a byte in the same cycle is dropped.
        if (load_req) begin
          state_d    = CNT_LO;
          word_idx_d = '0;
          csum_d     = '0;
          code_d     = ERR_NONE;
          pk_clr     = 1'b1;
        end
      end
      ERROR: begin
      end
      default: begin
        state_d = ERROR;
      end
    endcase

`ifdef BOOT_TIMEOUT_EN
    // idle_q counts cycles since the last byte, so the error shows
    // exactly TIMEOUT_CYCLES cycles after that byte.
    idle_d = '0;
    if (rx_valid) begin
      idle_d = 32'd1;
    end else if (state_q == CNT_HI || state_q == LOAD ||
                 state_q == CHECK) begin
      idle_d = idle_q + 32'd1;
      if (idle_d >= 32'(TIMEOUT_CYCLES)) begin
        state_d = ERROR;
        code_d  = ERR_TIMEOUT;
      end
    end
`endif

    core_reset_d = (state_d != RUN);
    busy_d       = (state_d != RUN) && (state_d != ERROR);
    done_d       = (state_d == RUN);
    err_d        = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CNT_LO;
      cnt_lo_q     <= '0;
      count_q      <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      core_reset_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      wd_q         <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
`ifdef BOOT_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      core_reset_q <= core_reset_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      code_q       <= code_d;
`ifdef BOOT_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign core_reset = core_reset_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wd    = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule
